// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its neighbours: the next-PC box,
// instruction memory, decode/execute and the halt/status logic.
interface fetch_sequencer_if #(
  parameter int PC_W    = 9,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  logic [PC_W-1:0]    pc_out;
  logic [PC_W-1:0]    pc_next_in;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic               instr_ready;
  logic               halt_req;
  logic               halted;
  logic               fetch_err;
  logic [CNT_W-1:0]   retired_cnt;

  modport master (
    output pc_out, imem_req, imem_addr, instr_valid, instr_data,
           halted, fetch_err, retired_cnt,
    input  pc_next_in, imem_ack, imem_rdata, instr_ready, halt_req
  );

  modport slave (
    input  pc_out, imem_req, imem_addr, instr_valid, instr_data,
           halted, fetch_err, retired_cnt,
    output pc_next_in, imem_ack, imem_rdata, instr_ready, halt_req
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner: fetches from imem over req/ack, issues to decode over
// valid/ready, then loads the PC from the external next-PC box.
module fetch_sequencer #(
  parameter int PC_W     = 9,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    ADVANCE,
    HALTED
  } state_t;

  state_t             state;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [TO_W-1:0]    to_cnt;
  logic [CNT_W-1:0]   retired_q;
  logic               req_q;
  logic               valid_q;
  logic               halted_q;
  logic               err_q;

  // Outputs are decoded into flops alongside each state transition so that
  // every handshake signal leaves the block glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= PC_W'(RESET_PC);
      instr_q   <= '0;
      to_cnt    <= '0;
      retired_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of pc_q, to_cnt and retired_q regardless of order.
      case (state)
        IDLE: begin
          if (bus.halt_req) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state <= FETCH;
            req_q <= 1'b1;
          end
        end

        FETCH: begin
          // An ack arriving on the last permitted cycle still completes the fetch.
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            to_cnt  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= ISSUE;
          end else if (to_cnt == TO_LAST) begin
            err_q    <= 1'b1;
            req_q    <= 1'b0;
            halted_q <= 1'b1;
            state    <= HALTED;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ISSUE: begin
          if (bus.instr_ready) begin
            valid_q <= 1'b0;
            state   <= ADVANCE;
          end
        end

        ADVANCE: begin
          pc_q      <= bus.pc_next_in;
          retired_q <= retired_q + 1'b1;
          if (bus.halt_req) begin
            halted_q <= 1'b1;
            state    <= HALTED;
          end else begin
            req_q <= 1'b1;
            state <= FETCH;
          end
        end

        HALTED: begin
          state <= HALTED;
        end

        default: begin
          state    <= IDLE;
          req_q    <= 1'b0;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.imem_req    = req_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_data  = instr_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_err   = err_q;
  assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scenario tasks with randomized
// memory/decode timing checked against a per-instruction transaction model.
module tb_fetch_sequencer;

  localparam int PC_W    = 9;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 16;
  localparam int TMO     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_retired;

  fetch_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  fetch_sequencer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0), .TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pc_next_in  = '0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.halt_req    = 1'b0;
  endtask

  // Full reset and release; leaves the DUT in its first FETCH cycle.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    m_pc      = '0;
    m_retired = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    vectors++;
    if ({bus.pc_out, bus.imem_req, bus.instr_valid, bus.halted, bus.fetch_err} !== {9'd0, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_flags: pc=%0d req=%b valid=%b halted=%b err=%b, want pc=0 and all 0",
               bus.pc_out, bus.imem_req, bus.instr_valid, bus.halted, bus.fetch_err);
    end
    vectors++;
    if ({bus.retired_cnt, bus.instr_data} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_regs: retired=%0d data=%h, want 0 and 0000", bus.retired_cnt, bus.instr_data);
    end
    rst_n = 1'b1;
    vectors++;
    if (bus.imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_req: req=%b, want 0 before first edge", bus.imem_req);
    end
    step();
    vectors++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 9'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_first_fetch: req=%b addr=%0d valid=%b, want 1 0 0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    m_pc      = '0;
    m_retired = '0;
  endtask

  task automatic test_fetch_advance();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h1234;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'hdead;
    vectors++;
    if ({bus.instr_valid, bus.instr_data, bus.imem_req} !== {1'b1, 16'h1234, 1'b0}) begin
      miscompares++;
      $display("FAIL fa_issue: valid=%b data=%h req=%b, want 1 1234 0",
               bus.instr_valid, bus.instr_data, bus.imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({bus.instr_valid, bus.instr_data} !== {1'b1, 16'h1234}) begin
        miscompares++;
        $display("FAIL fa_stall%0d: valid=%b data=%h, want 1 1234", i, bus.instr_valid, bus.instr_data);
      end
    end
    bus.instr_ready = 1'b1;
    bus.pc_next_in  = 9'd3;
    step();
    bus.instr_ready = 1'b0;
    step();
    m_pc = 9'd3;
    m_retired++;
    vectors++;
    if ({bus.pc_out, bus.imem_addr, bus.imem_req, bus.retired_cnt} !== {9'd3, 9'd3, 1'b1, 16'd1}) begin
      miscompares++;
      $display("FAIL fa_advance: pc=%0d addr=%0d req=%b retired=%0d, want 3 3 1 1",
               bus.pc_out, bus.imem_addr, bus.imem_req, bus.retired_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] exp_pc;
    int unsigned t0;
    int waited;
    do_reset();
    bus.imem_ack    = 1'b1;
    bus.instr_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      exp_pc = m_pc + 9'd3;
      bus.pc_next_in = exp_pc;
      bus.imem_rdata = 16'($urandom);
      t0 = cyc;
      waited = 0;
      while (bus.pc_out === m_pc && waited < 10) begin
        step();
        waited++;
      end
      vectors++;
      if (bus.pc_out !== exp_pc || (cyc - t0) != 3) begin
        miscompares++;
        $display("FAIL b2b_step%0d: pc=%0d after %0d cycles, want pc=%0d after 3",
                 n, bus.pc_out, cyc - t0, exp_pc);
      end
      m_pc = exp_pc;
      m_retired++;
    end
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b0;
    vectors++;
    if (bus.retired_cnt !== 16'd3 || bus.pc_out !== 9'd9) begin
      miscompares++;
      $display("FAIL b2b_final: pc=%0d retired=%0d, want 9 3", bus.pc_out, bus.retired_cnt);
    end
  endtask

  // One instruction with arbitrary memory and decode latency; starts and ends in FETCH.
  task automatic run_instr(input int ack_dly, input int rdy_dly,
                           input logic [PC_W-1:0] nxt, input logic [INSTR_W-1:0] data);
    int unsigned t0;
    t0 = cyc;
    for (int i = 0; i < ack_dly; i++) begin
      bus.pc_next_in = PC_W'($urandom);
      vectors++;
      if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, m_pc, 1'b0}) begin
        miscompares++;
        $display("FAIL ri_fetch_wait: req=%b addr=%0d valid=%b, want 1 %0d 0",
                 bus.imem_req, bus.imem_addr, bus.instr_valid, m_pc);
      end
      step();
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = INSTR_W'($urandom);
    for (int i = 0; i < rdy_dly; i++) begin
      vectors++;
      if ({bus.instr_valid, bus.instr_data, bus.imem_req} !== {1'b1, data, 1'b0}) begin
        miscompares++;
        $display("FAIL ri_issue_hold: valid=%b data=%h req=%b, want 1 %h 0",
                 bus.instr_valid, bus.instr_data, bus.imem_req, data);
      end
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = INSTR_W'($urandom);
      step();
      bus.imem_ack = 1'b0;
    end
    vectors++;
    if ({bus.instr_valid, bus.instr_data} !== {1'b1, data}) begin
      miscompares++;
      $display("FAIL ri_issue: valid=%b data=%h, want 1 %h", bus.instr_valid, bus.instr_data, data);
    end
    bus.instr_ready = 1'b1;
    bus.pc_next_in  = nxt;
    step();
    bus.instr_ready = 1'b0;
    vectors++;
    if ({bus.instr_valid, bus.imem_req, bus.pc_out} !== {2'b00, m_pc}) begin
      miscompares++;
      $display("FAIL ri_advance: valid=%b req=%b pc=%0d, want 0 0 %0d",
               bus.instr_valid, bus.imem_req, bus.pc_out, m_pc);
    end
    step();
    bus.pc_next_in = PC_W'($urandom);
    m_pc = nxt;
    m_retired++;
    vectors++;
    if ({bus.imem_req, bus.imem_addr, bus.pc_out, bus.retired_cnt} !== {1'b1, m_pc, m_pc, m_retired}) begin
      miscompares++;
      $display("FAIL ri_next: req=%b addr=%0d pc=%0d retired=%0d, want 1 %0d %0d %0d",
               bus.imem_req, bus.imem_addr, bus.pc_out, bus.retired_cnt, m_pc, m_pc, m_retired);
    end
    vectors++;
    if ((cyc - t0) != unsigned'(ack_dly + rdy_dly + 3)) begin
      miscompares++;
      $display("FAIL ri_latency: took %0d cycles, want %0d", cyc - t0, ack_dly + rdy_dly + 3);
    end
  endtask

  task automatic test_random_stream();
    logic [PC_W-1:0] nxt;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       nxt = m_pc;
        1:       nxt = m_pc + 1'b1;
        default: nxt = PC_W'($urandom);
      endcase
      run_instr($urandom_range(0, TMO - 1), $urandom_range(0, 4), nxt, INSTR_W'($urandom));
    end
    // Boundary cases: ack on the last permitted cycle, and PC wrap from the top.
    run_instr(TMO - 1, 0, 9'd511, 16'hbeef);
    run_instr(0, 0, 9'd0, 16'h0f0f);
  endtask

  task automatic test_halt();
    logic [PC_W-1:0]    nxt;
    logic [INSTR_W-1:0] d;
    nxt = PC_W'($urandom);
    d   = INSTR_W'($urandom);
    bus.halt_req = 1'b1;
    repeat (2) step();
    vectors++;
    if ({bus.imem_req, bus.halted} !== 2'b10) begin
      miscompares++;
      $display("FAIL halt_fetch_kept: req=%b halted=%b, want 1 0", bus.imem_req, bus.halted);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    step();
    bus.imem_ack = 1'b0;
    vectors++;
    if ({bus.instr_valid, bus.instr_data} !== {1'b1, d}) begin
      miscompares++;
      $display("FAIL halt_issue: valid=%b data=%h, want 1 %h", bus.instr_valid, bus.instr_data, d);
    end
    bus.instr_ready = 1'b1;
    bus.pc_next_in  = nxt;
    repeat (2) step();
    m_pc = nxt;
    m_retired++;
    vectors++;
    if ({bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out, bus.retired_cnt} !== {3'b100, m_pc, m_retired}) begin
      miscompares++;
      $display("FAIL halt_after_adv: halted=%b req=%b valid=%b pc=%0d retired=%0d, want 1 0 0 %0d %0d",
               bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out, bus.retired_cnt, m_pc, m_retired);
    end
    bus.halt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = INSTR_W'($urandom);
      bus.pc_next_in = PC_W'($urandom);
      step();
      vectors++;
      if ({bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out, bus.instr_data, bus.retired_cnt} !==
          {3'b100, m_pc, d, m_retired}) begin
        miscompares++;
        $display("FAIL halt_hold%0d: halted=%b req=%b valid=%b pc=%0d data=%h retired=%0d",
                 i, bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out, bus.instr_data, bus.retired_cnt);
      end
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    logic [INSTR_W-1:0] d;
    do_reset();
    d = INSTR_W'($urandom);
    run_instr(1, 1, PC_W'($urandom_range(1, 511)), d);
    for (int i = 0; i < TMO - 1; i++) step();
    vectors++;
    if ({bus.imem_req, bus.fetch_err, bus.halted} !== 3'b100) begin
      miscompares++;
      $display("FAIL tmo_before: req=%b err=%b halted=%b after %0d idle cycles, want 1 0 0",
               bus.imem_req, bus.fetch_err, bus.halted, TMO - 1);
    end
    step();
    vectors++;
    if ({bus.fetch_err, bus.halted, bus.imem_req, bus.pc_out} !== {3'b110, m_pc}) begin
      miscompares++;
      $display("FAIL tmo_fault: err=%b halted=%b req=%b pc=%0d, want 1 1 0 %0d",
               bus.fetch_err, bus.halted, bus.imem_req, bus.pc_out, m_pc);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = ~d;
    step();
    bus.imem_ack = 1'b0;
    step();
    vectors++;
    if ({bus.fetch_err, bus.halted, bus.instr_valid, bus.instr_data, bus.pc_out} !== {3'b110, d, m_pc}) begin
      miscompares++;
      $display("FAIL tmo_late_ack: err=%b halted=%b valid=%b data=%h pc=%0d, want 1 1 0 %h %0d",
               bus.fetch_err, bus.halted, bus.instr_valid, bus.instr_data, bus.pc_out, d, m_pc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int n = 0; n < 3; n++)
      run_instr($urandom_range(0, 3), 0, PC_W'($urandom_range(1, 511)), INSTR_W'($urandom));
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h5a5a;
    step();
    bus.imem_ack = 1'b0;
    vectors++;
    if (bus.instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_in_issue: valid=%b, want 1", bus.instr_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.instr_valid, bus.imem_req, bus.retired_cnt, bus.pc_out, bus.fetch_err} !== {2'b00, 16'd0, 9'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL ar_immediate: valid=%b req=%b retired=%0d pc=%0d err=%b, want 0 0 0 0 0",
               bus.instr_valid, bus.imem_req, bus.retired_cnt, bus.pc_out, bus.fetch_err);
    end
    step();
    rst_n = 1'b1;
    m_pc      = '0;
    m_retired = '0;
    step();
    vectors++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 9'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL ar_restart: req=%b addr=%0d valid=%b, want 1 0 0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    run_instr(2, 1, 9'd42, 16'hc0de);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch_advance();
    test_back_to_back();
    test_random_stream();
    test_halt();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
